// File: rtl/e2h_pkg.sv
// -----------------------------------------------------------------------------
// e2h_pkg
// Shared definitions for the English->Hindi transliteration path:
//   - code width and the special codes (SPACE, INHERENT_A, HALANT, ERR_CODE)
//   - FSM state enum used by english_to_hindi_mapper
//   - the forward Hindi->English table and the inverse lookup derived from it
// The build macro E2H_HALANT_EN (see english_to_hindi_mapper) decides whether
// S_HALANT is ever entered; the enum keeps the encoding stable either way.
// -----------------------------------------------------------------------------
package e2h_pkg;

    localparam int CODE_W = 7;

    localparam logic [CODE_W-1:0] SPACE      = 7'b1111111;
    localparam logic [CODE_W-1:0] INHERENT_A = 7'b0000000;
    localparam logic [CODE_W-1:0] HALANT     = 7'b0110000;
    localparam logic [CODE_W-1:0] ERR_CODE   = 7'b1111110;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONS   = 2'd1,
        S_HALANT = 2'd2
    } e2h_state_t;

    typedef struct packed {
        logic              hit;
        logic [CODE_W-1:0] code;
    } e2h_map_t;

    // Forward table, one entry per Hindi code: {hindi, english}.
    // This is the same source the Hindi->English stage is built from; the
    // reverse lookup below is derived from it rather than kept separately.
    localparam int MAP_N = 21;
    localparam logic [2*CODE_W-1:0] FWD_TABLE [MAP_N] = '{
        {7'b0000000, 7'b0000000},   // a (inherent)
        {7'b0000001, 7'b0010101},   // aa
        {7'b0000010, 7'b0010010},   // i
        {7'b0000011, 7'b0010011},   // ii
        {7'b0000100, 7'b0010110},   // u
        {7'b0000101, 7'b0010111},   // uu
        {7'b0000110, 7'b0011000},   // e
        {7'b0000111, 7'b0011001},   // ai
        {7'b1000000, 7'b1000111},   // ka
        {7'b1000001, 7'b1001000},   // kha
        {7'b1000010, 7'b1000100},   // ga
        {7'b1000011, 7'b1000101},   // gha
        {7'b1000100, 7'b1010011},   // ca
        {7'b1010000, 7'b1000010},   // dental da  (shares roman code with retroflex)
        {7'b1001100, 7'b1000010},   // retroflex da
        {7'b1010100, 7'b1010000},   // na
        {7'b1011000, 7'b1010101},   // pa
        {7'b1011100, 7'b1011001},   // ma
        {7'b1100000, 7'b1011101},   // ra
        {7'b1100101, 7'b1100010},   // sha (shares roman code with sa)
        {7'b1100100, 7'b1100010}    // sa
    };

    function automatic logic is_consonant(input logic [CODE_W-1:0] code);
        return code[CODE_W-1];
    endfunction

    // English -> Hindi. Where several Hindi codes share one English code the
    // lowest Hindi code wins, independent of table order.
    function automatic e2h_map_t e2h_lookup(input logic [CODE_W-1:0] en);
        e2h_map_t r;
        r.hit  = 1'b0;
        r.code = ERR_CODE;
        if (en == SPACE) begin
            r.hit  = 1'b1;
            r.code = SPACE;
        end else begin
            for (int i = 0; i < MAP_N; i++) begin
                if ((FWD_TABLE[i][CODE_W-1:0] == en) &&
                    (!r.hit || (FWD_TABLE[i][2*CODE_W-1:CODE_W] < r.code))) begin
                    r.hit  = 1'b1;
                    r.code = FWD_TABLE[i][2*CODE_W-1:CODE_W];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/e2h_fifo.sv
// -----------------------------------------------------------------------------
// e2h_fifo
// Synchronous FIFO with occupancy output.
//   clock, reset_n : clock, asynchronous active-low reset (pointers/level only)
//   wr_en, wr_data : write port (ignored when full unless a read frees a slot)
//   rd_en          : pop the head entry (ignored when empty)
//   rd_data        : current head entry (undefined when empty)
//   level          : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module e2h_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 7
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             do_wr, do_rd;

    always_comb begin
        do_rd    = rd_en && (level_q != '0);
        do_wr    = wr_en && ((level_q != FULL_LVL) || do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_wr && !do_rd) begin
            level_d = level_q + (PTR_W+1)'(1);
        end else if (do_rd && !do_wr) begin
            level_d = level_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset: emptiness is tracked by level_q alone.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

endmodule

// File: rtl/english_to_hindi_mapper.sv
// -----------------------------------------------------------------------------
// english_to_hindi_mapper
// Streaming English(roman) -> Hindi code transliteration. Rebuilds conjuncts
// by inserting a halant between back-to-back consonants and drops the
// inherent "a" that follows a consonant. A small output FIFO absorbs the
// one-in/two-out expansion of a conjunct.
//
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake, in_code is the English code
//                           (bit6=1 consonant, bit6=0 vowel)
//   out_valid/out_ready   : output handshake, out_code is the Hindi code
//   fifo_level            : output FIFO occupancy
//   err                   : sticky flag, set by any unmapped input code
//
// Build option:
//   E2H_HALANT_EN defined   : consonant,consonant -> HALANT then consonant
//                             (two FIFO writes over two cycles via S_HALANT)
//   E2H_HALANT_EN undefined : consonant,consonant -> second consonant only
// -----------------------------------------------------------------------------
module english_to_hindi_mapper
    import e2h_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [6:0]                  in_code,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [6:0]                  out_code,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        err
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    e2h_state_t        state_q, state_d;
    logic              err_q, err_d;
    e2h_map_t          in_map;
    logic              in_fire, out_fire;
    logic              wr_en;
    logic [CODE_W-1:0] wr_data;
    logic [CODE_W-1:0] rd_data;
    logic [LVL_W-1:0]  free_cnt;
    logic              room_ok;
`ifdef E2H_HALANT_EN
    logic [CODE_W-1:0] hold_q, hold_d;
`endif

    assign in_map   = e2h_lookup(in_code);
    assign free_cnt = DEPTH_LVL - fifo_level;

`ifdef E2H_HALANT_EN
    // Two free slots are demanded in every state so a HALANT/consonant pair
    // can always complete even if downstream stalls right after acceptance.
    assign room_ok  = (free_cnt >= LVL_W'(2));
    assign in_ready = (state_q != S_HALANT) && room_ok;
`else
    assign room_ok  = (free_cnt >= LVL_W'(1));
    assign in_ready = room_ok;
`endif

    assign in_fire   = in_valid && in_ready;
    assign out_valid = (fifo_level != '0);
    assign out_fire  = out_valid && out_ready;
    // The FIFO storage is not reset, so the head is masked while empty.
    assign out_code  = out_valid ? rd_data : '0;
    assign err       = err_q;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_data = in_map.code;
`ifdef E2H_HALANT_EN
        hold_d  = hold_q;
`endif
        if (in_fire && !in_map.hit) begin
            err_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    wr_en = 1'b1;
                    // Unmapped consonant-class codes still open a consonant context.
                    if ((in_code != SPACE) && is_consonant(in_code)) begin
                        state_d = S_CONS;
                    end
                end
            end
            S_CONS: begin
                if (in_fire) begin
                    if (in_code == SPACE) begin
                        wr_en   = 1'b1;
                        state_d = S_IDLE;
                    end else if (is_consonant(in_code)) begin
`ifdef E2H_HALANT_EN
                        wr_en   = 1'b1;
                        wr_data = HALANT;
                        hold_d  = in_map.code;
                        state_d = S_HALANT;
`else
                        wr_en   = 1'b1;
                        state_d = S_CONS;
`endif
                    end else begin
                        // The inherent vowel is implicit after a consonant.
                        wr_en   = (in_code != INHERENT_A);
                        state_d = S_IDLE;
                    end
                end
            end
`ifdef E2H_HALANT_EN
            S_HALANT: begin
                wr_en   = 1'b1;
                wr_data = hold_q;
                state_d = S_CONS;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

`ifdef E2H_HALANT_EN
    // Only meaningful in S_HALANT, which reset leaves, so no reset needed.
    always_ff @(posedge clock) begin
        hold_q <= hold_d;
    end
`endif

    e2h_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (out_fire),
        .rd_data (rd_data),
        .level   (fifo_level)
    );

endmodule

// File: tb/tb_english_to_hindi_mapper.sv
module tb_english_to_hindi_mapper;

    localparam int DEPTH = 4;
`ifdef E2H_HALANT_EN
    localparam bit HAL = 1'b1;
`else
    localparam bit HAL = 1'b0;
`endif
    localparam logic [6:0] C_SPACE  = 7'b1111111;
    localparam logic [6:0] C_HALANT = 7'b0110000;
    localparam logic [6:0] C_ERR    = 7'b1111110;

    logic       clock;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_code;
    logic [2:0] fifo_level;
    logic       err;

    english_to_hindi_mapper #(.FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .fifo_level (fifo_level),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int rdy_low  = 0;

    // Reference forward table {hindi, english}; the inverse is derived below.
    localparam int N_FWD = 21;
    logic [6:0] fwd_h [N_FWD] = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07,
                                  7'h40, 7'h41, 7'h42, 7'h43, 7'h44, 7'h50, 7'h4C, 7'h54,
                                  7'h58, 7'h5C, 7'h60, 7'h65, 7'h64};
    logic [6:0] fwd_e [N_FWD] = '{7'b0000000, 7'b0010101, 7'b0010010, 7'b0010011, 7'b0010110,
                                  7'b0010111, 7'b0011000, 7'b0011001, 7'b1000111, 7'b1001000,
                                  7'b1000100, 7'b1000101, 7'b1010011, 7'b1000010, 7'b1000010,
                                  7'b1010000, 7'b1010101, 7'b1011001, 7'b1011101, 7'b1100010,
                                  7'b1100010};
    logic [6:0] inv    [128];
    bit         inv_ok [128];

    // Behavioural model: expected FIFO contents plus conjunct context.
    logic [6:0] mq [$];
    logic [6:0] got [$];
    logic       m_pend, m_cons, m_err;
    logic [6:0] m_hold;

    typedef struct {
        logic [6:0] code;
        logic [6:0] exp;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_map(input logic [6:0] e);
        if (e == C_SPACE) return {1'b1, C_SPACE};
        if (inv_ok[e]) return {1'b1, inv[e]};
        return {1'b0, C_ERR};
    endfunction

    task automatic model_accept(input logic [6:0] c);
        logic [7:0] m;
        m = ref_map(c);
        if (!m[7]) m_err = 1'b1;
        if (c == C_SPACE) begin
            mq.push_back(C_SPACE);
            m_cons = 1'b0;
        end else if (c[6]) begin
            if (m_cons && HAL) begin
                mq.push_back(C_HALANT);
                m_hold = m[6:0];
                m_pend = 1'b1;
            end else begin
                mq.push_back(m[6:0]);
            end
            m_cons = 1'b1;
        end else begin
            if (!(m_cons && c == 7'b0000000)) mq.push_back(m[6:0]);
            m_cons = 1'b0;
        end
    endtask

    // One clock cycle: drive, check combinational outputs, step model.
    task automatic cycle(input logic iv, input logic [6:0] ic, input logic ordy);
        logic exp_rdy, in_f, out_f;
        in_valid  = iv;
        in_code   = ic;
        out_ready = ordy;
        #1;
        exp_rdy = !m_pend && ((DEPTH - mq.size()) >= (HAL ? 2 : 1));
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check("out_code", 32'(out_code), 32'(mq[0]));
        check("fifo_level", 32'(fifo_level), 32'(mq.size()));
        if (!in_ready) rdy_low++;
        in_f  = iv && exp_rdy;
        out_f = ordy && (mq.size() != 0);
        if (out_f) got.push_back(out_code);
        @(posedge clock);
        #1;
        if (out_f) void'(mq.pop_front());
        if (m_pend) begin
            mq.push_back(m_hold);
            m_pend = 1'b0;
        end else if (in_f) begin
            model_accept(ic);
        end
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 7'b0000000, 1'b1);
    endtask

    task automatic check_got(input string name, input logic [6:0] exp_q [$]);
        check({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check(name, 32'(got[i]), 32'(exp_q[i]));
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_code   = 7'b0000000;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        mq.delete();
        m_pend = 1'b0;
        m_cons = 1'b0;
        m_err  = 1'b0;
    endtask

    logic [6:0] exp_q [$];
    logic [6:0] pool [16] = '{7'b1000111, 7'b1000100, 7'b1000010, 7'b1100010, 7'b1011101,
                              7'b0010101, 7'b0010010, 7'b0011001, 7'b0000000, 7'b0000000,
                              7'b1111111, 7'b1111000, 7'b0110000, 7'b1010000, 7'b1001000,
                              7'b1111110};

    initial begin
        for (int i = 0; i < 128; i++) begin
            inv[i]    = 7'b0;
            inv_ok[i] = 1'b0;
        end
        for (int i = 0; i < N_FWD; i++) begin
            if (!inv_ok[fwd_e[i]] || fwd_h[i] < inv[fwd_e[i]]) begin
                inv[fwd_e[i]]    = fwd_h[i];
                inv_ok[fwd_e[i]] = 1'b1;
            end
        end
        vecs[0] = '{7'b1000111, 7'b1000000};
        vecs[1] = '{7'b0010101, 7'b0000001};
        vecs[2] = '{7'b1000010, 7'b1001100};
        vecs[3] = '{7'b1100010, 7'b1100100};
        vecs[4] = '{7'b1000100, 7'b1000010};
        vecs[5] = '{7'b0000000, 7'b0000000};
        vecs[6] = '{7'b1111111, 7'b1111111};
        vecs[7] = '{7'b1111000, 7'b1111110};
        vecs[8] = '{7'b0110000, 7'b1111110};
        m_pend = 1'b0; m_cons = 1'b0; m_err = 1'b0; m_hold = 7'b0;

        // Reset values while reset is held, then ready after release.
        in_valid = 1'b0; in_code = 7'b0; out_ready = 1'b0; reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_out_code", 32'(out_code), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        do_reset();
        @(posedge clock);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single codes from S_IDLE, visible one cycle after acceptance.
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, C_SPACE, 1'b1);
            cycle(1'b1, vecs[i].code, 1'b1);
            #1;
            check("vec_valid", 32'(out_valid), 32'd1);
            check("vec_code", 32'(out_code), 32'(vecs[i].exp));
        end
        drain(2);
        check("err_sticky", 32'(err), 32'd1);

        // Conjunct: ka, ga.
        do_reset();
        got.delete();
        rdy_low = 0;
        cycle(1'b1, 7'b1000111, 1'b1);
        cycle(1'b1, 7'b1000100, 1'b1);
        drain(4);
`ifdef E2H_HALANT_EN
        exp_q = '{7'b1000000, C_HALANT, 7'b1000010};
`else
        exp_q = '{7'b1000000, 7'b1000010};
`endif
        check_got("conjunct", exp_q);
        check("conjunct_ready_low", 32'(rdy_low), HAL ? 32'd1 : 32'd0);

        // Inherent a dropped after a consonant; FSM back in S_IDLE afterwards.
        got.delete();
        cycle(1'b1, 7'b1000111, 1'b1);
        cycle(1'b1, 7'b0000000, 1'b1);
        cycle(1'b1, 7'b0010101, 1'b1);
        cycle(1'b1, 7'b1000111, 1'b1);
        cycle(1'b1, 7'b0000000, 1'b1);
        cycle(1'b1, 7'b0000000, 1'b1);
        drain(4);
        exp_q = '{7'b1000000, 7'b0000001, 7'b1000000, 7'b0000000};
        check_got("inherent_a", exp_q);

        // Backpressure: stream consonants with out_ready low, then release.
        do_reset();
        got.delete();
        for (int i = 0; i < 12; i++) cycle(1'b1, pool[i % 4], 1'b0);
        #1;
        check("bp_level", 32'(fifo_level), HAL ? 32'(DEPTH - 1) : 32'(DEPTH));
        check("bp_in_ready", 32'(in_ready), 32'd0);
        drain(8);
`ifdef E2H_HALANT_EN
        exp_q = '{7'b1000000, C_HALANT, 7'b1000010};
`else
        exp_q = '{7'b1000000, 7'b1000010, 7'b1001100, 7'b1100100};
`endif
        check_got("bp_order", exp_q);

        // Async reset mid-conjunct (S_HALANT when halant insertion is built in).
        do_reset();
        cycle(1'b1, 7'b1000111, 1'b0);
        cycle(1'b1, 7'b1000100, 1'b0);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_fifo_level", 32'(fifo_level), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        mq.delete(); m_pend = 1'b0; m_cons = 1'b0; m_err = 1'b0;
        got.delete();
        cycle(1'b1, 7'b1000111, 1'b1);
        drain(4);
        exp_q = '{7'b1000000};
        check_got("arst_next", exp_q);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [6:0] c;
            c = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127))
                                            : pool[$urandom_range(0, 15)];
            cycle(1'($urandom_range(0, 3) != 0), c, 1'($urandom_range(0, 2) != 0));
        end
        drain(12);
        check("rand_drained", 32'(mq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
